// File: rtl/plat_type_gen.sv
// Platform type generator. An LFSR draw is weighted by a score-derived difficulty
// level, and fairness rules then limit Brown runs and force a periodic Green.
module plat_type_gen #(
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int unsigned LVL1_SCORE      = 500,
    parameter int unsigned LVL2_SCORE      = 2000,
    parameter int unsigned LVL3_SCORE      = 5000,
    parameter int unsigned MAX_BROWN_RUN   = 1,
    parameter int unsigned FORCE_GREEN_GAP = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        spawn_req,
    input  logic [15:0] score,
    output logic [2:0]  type_trigger,
    output logic        type_valid,
    output logic        busy,
    output logic        req_drop
);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int unsigned BW   = (MAX_BROWN_RUN   > 1) ? $clog2(MAX_BROWN_RUN + 1)   : 1;
    localparam int unsigned GW   = (FORCE_GREEN_GAP > 1) ? $clog2(FORCE_GREEN_GAP + 1) : 1;
    localparam logic [BW-1:0] BROWN_MAX = BW'(MAX_BROWN_RUN);
    localparam logic [GW-1:0] GREEN_GAP = GW'(FORCE_GREEN_GAP);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CHECK, S_EMIT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [2:0]    cand_q, cand_d;
    logic          pending_q, pending_d;
    logic [BW-1:0] brown_q, brown_d;
    logic [GW-1:0] ng_q, ng_d;
    logic [2:0]    trig_q, trig_d;
    logic          valid_q, valid_d;
    logic          drop_q, drop_d;
    logic [1:0]    level;
    logic [2:0]    fair;

    function automatic logic [2:0] draw_code(input logic [1:0] lvl, input logic [6:0] r);
        logic [6:0] ub_g, ub_w, ub_b, ub_y;
        ub_g = 7'd95; ub_w = 7'd111; ub_b = 7'd127; ub_y = 7'd127;
        unique case (lvl)
            2'd0: begin ub_g = 7'd95; ub_w = 7'd111; ub_b = 7'd127; ub_y = 7'd127; end
            2'd1: begin ub_g = 7'd63; ub_w = 7'd79;  ub_b = 7'd103; ub_y = 7'd111; end
            2'd2: begin ub_g = 7'd39; ub_w = 7'd63;  ub_b = 7'd95;  ub_y = 7'd103; end
            2'd3: begin ub_g = 7'd23; ub_w = 7'd47;  ub_b = 7'd87;  ub_y = 7'd95;  end
        endcase
        if (r <= ub_g)      draw_code = 3'd0;
        else if (r <= ub_w) draw_code = 3'd1;
        else if (r <= ub_b) draw_code = 3'd2;
        else if (r <= ub_y) draw_code = 3'd3;
        else                draw_code = 3'd4;
    endfunction

    always_comb begin
        if (32'(score) < LVL1_SCORE)      level = 2'd0;
        else if (32'(score) < LVL2_SCORE) level = 2'd1;
        else if (32'(score) < LVL3_SCORE) level = 2'd2;
        else                              level = 2'd3;
    end

    always_comb begin
        fair = cand_q;
        if (ng_q == GREEN_GAP)                          fair = 3'd0;
        else if (cand_q == 3'd4 && brown_q == BROWN_MAX) fair = 3'd0;
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        cand_d    = cand_q;
        pending_d = pending_q;
        brown_d   = brown_q;
        ng_d      = ng_q;
        trig_d    = trig_q;
        valid_d   = 1'b0;
        drop_d    = 1'b0;

        if (state_q != S_IDLE && spawn_req) begin
            if (pending_q) drop_d    = 1'b1;
            else           pending_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: if (spawn_req) state_d = S_DRAW;
            S_DRAW: begin
                cand_d  = draw_code(level, lfsr_q[6:0]);
                state_d = S_CHECK;
            end
            // Emission is registered on leaving CHECK so type_trigger/type_valid
            // are both visible throughout the EMIT cycle.
            S_CHECK: begin
                trig_d  = fair;
                valid_d = 1'b1;
                brown_d = (fair == 3'd4) ? ((brown_q == BROWN_MAX) ? brown_q : brown_q + BW'(1)) : '0;
                ng_d    = (fair != 3'd0) ? ((ng_q == GREEN_GAP) ? ng_q : ng_q + GW'(1)) : '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (pending_q || spawn_req) begin
                    state_d   = S_DRAW;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            cand_q    <= '0;
            pending_q <= 1'b0;
            brown_q   <= '0;
            ng_q      <= '0;
            trig_q    <= '0;
            valid_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cand_q    <= cand_d;
            pending_q <= pending_d;
            brown_q   <= brown_d;
            ng_q      <= ng_d;
            trig_q    <= trig_d;
            valid_q   <= valid_d;
            drop_q    <= drop_d;
        end
    end

    assign type_trigger = trig_q;
    assign type_valid   = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign req_drop     = drop_q;

endmodule

// File: tb/tb_plat_type_gen.sv
// Bench for plat_type_gen: directed timing checks plus randomized request streams
// compared against a table/history reference model; a second instance uses FORCE_GREEN_GAP=1.
module tb_plat_type_gen;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        spawn_req;
    logic [15:0] score;
    logic [2:0]  tt_a, tt_b;
    logic        tv_a, tv_b, busy_a, busy_b, drop_a, drop_b;

    int total = 0;
    int bad   = 0;

    plat_type_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .spawn_req(spawn_req), .score(score),
        .type_trigger(tt_a), .type_valid(tv_a), .busy(busy_a), .req_drop(drop_a)
    );

    plat_type_gen #(.FORCE_GREEN_GAP(1)) dut_g (
        .Clk(Clk), .Reset_n(Reset_n), .spawn_req(spawn_req), .score(score),
        .type_trigger(tt_b), .type_valid(tv_b), .busy(busy_b), .req_drop(drop_b)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR: Fibonacci, taps 16,14,13,11 expressed as a parity mask.
    logic [15:0] m_lfsr;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    int q_a[$];
    int q_b[$];
    int cnt_a[5];
    int prev_a, run_nz_a, viol_b2, viol_nz7, prev_b, viol_g1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int table_code(input int sc, input int r);
        int ub[4];
        if (sc < 500)       ub = '{95, 111, 127, 127};
        else if (sc < 2000) ub = '{63, 79, 103, 111};
        else if (sc < 5000) ub = '{39, 63, 95, 103};
        else                ub = '{23, 47, 87, 95};
        for (int k = 0; k < 4; k++) if (r <= ub[k]) return k;
        return 4;
    endfunction

    function automatic int fair_code(input int hist[$], input int cand, input int gap, input int maxb);
        int ng = 0;
        int br = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] != 0; i--) ng++;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == 4; i--) br++;
        if (ng >= gap) return 0;
        if (cand == 4 && br >= maxb) return 0;
        return cand;
    endfunction

    task automatic clear_stats();
        for (int k = 0; k < 5; k++) cnt_a[k] = 0;
        viol_b2 = 0; viol_nz7 = 0;
    endtask

    task automatic clear_history();
        q_a.delete(); q_b.delete();
        prev_a = 0; run_nz_a = 0; prev_b = 0;
    endtask

    // Called in an emission cycle: checks both instances and records observed codes.
    task automatic emit_check(input string tag, input int ea, input int eb);
        chk({tag, "_valid_a"}, 32'(tv_a), 32'd1);
        chk({tag, "_valid_b"}, 32'(tv_b), 32'd1);
        chk({tag, "_type_a"}, 32'(tt_a), 32'(ea));
        chk({tag, "_type_b"}, 32'(tt_b), 32'(eb));
        q_a.push_back(ea); q_b.push_back(eb);
        if (q_a.size() > 16) void'(q_a.pop_front());
        if (q_b.size() > 16) void'(q_b.pop_front());
        if (tt_a <= 3'd4) cnt_a[tt_a]++;
        if (tt_a == 3'd4 && prev_a == 4) viol_b2++;
        if (tt_a != 3'd0) run_nz_a++; else run_nz_a = 0;
        if (run_nz_a >= 7) viol_nz7++;
        if (tt_b != 3'd0 && prev_b != 0) viol_g1++;
        prev_a = int'(tt_a); prev_b = int'(tt_b);
    endtask

    // Single isolated request; called at a negedge with the DUT idle.
    task automatic do_req(input logic [15:0] sc, input int gap);
        int r, cand, ea, eb;
        repeat (gap) @(negedge Clk);
        score = sc; spawn_req = 1'b1;
        @(negedge Clk);
        spawn_req = 1'b0;
        r = int'(m_lfsr[6:0]);
        cand = table_code(int'(sc), r);
        ea = fair_code(q_a, cand, 6, 1);
        eb = fair_code(q_b, cand, 1, 1);
        chk("draw_busy", 32'(busy_a), 32'd1);
        chk("draw_valid", 32'(tv_a), 32'd0);
        @(negedge Clk);
        chk("check_valid", 32'(tv_a), 32'd0);
        @(negedge Clk);
        emit_check("emit", ea, eb);
        @(negedge Clk);
        chk("post_valid", 32'(tv_a), 32'd0);
        chk("post_hold", 32'(tt_a), 32'(ea));
        chk("post_busy", 32'(busy_a), 32'd0);
    endtask

    task automatic triple_req(input logic [15:0] sc);
        int r1, r2, e1a, e1b, e2a, e2b;
        score = sc; spawn_req = 1'b1;
        @(negedge Clk);
        r1 = int'(m_lfsr[6:0]);
        chk("tri1_busy", 32'(busy_a), 32'd1);
        chk("tri1_drop", 32'(drop_a), 32'd0);
        @(negedge Clk);
        chk("tri2_busy", 32'(busy_a), 32'd1);
        chk("tri2_valid", 32'(tv_a), 32'd0);
        chk("tri2_drop", 32'(drop_a), 32'd0);
        @(negedge Clk);
        spawn_req = 1'b0;
        e1a = fair_code(q_a, table_code(int'(sc), r1), 6, 1);
        e1b = fair_code(q_b, table_code(int'(sc), r1), 1, 1);
        emit_check("tri3", e1a, e1b);
        chk("tri3_drop_a", 32'(drop_a), 32'd1);
        chk("tri3_drop_b", 32'(drop_b), 32'd1);
        @(negedge Clk);
        r2 = int'(m_lfsr[6:0]);
        chk("tri4_busy", 32'(busy_a), 32'd1);
        chk("tri4_valid", 32'(tv_a), 32'd0);
        chk("tri4_drop", 32'(drop_a), 32'd0);
        @(negedge Clk);
        chk("tri5_busy", 32'(busy_b), 32'd1);
        chk("tri5_valid", 32'(tv_a), 32'd0);
        @(negedge Clk);
        e2a = fair_code(q_a, table_code(int'(sc), r2), 6, 1);
        e2b = fair_code(q_b, table_code(int'(sc), r2), 1, 1);
        emit_check("tri6", e2a, e2b);
        chk("tri6_drop", 32'(drop_a), 32'd0);
        @(negedge Clk);
        chk("tri7_busy", 32'(busy_a), 32'd0);
        chk("tri7_valid", 32'(tv_a), 32'd0);
        chk("tri7_drop", 32'(drop_a), 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0; spawn_req = 1'b0; score = 16'd0;
        clear_history(); clear_stats(); viol_g1 = 0;
        repeat (3) @(negedge Clk);
        chk("rst_type", 32'(tt_a), 32'd0);
        chk("rst_valid", 32'(tv_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_drop", 32'(drop_a), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        Reset_n = 1'b1;
        repeat (9) @(negedge Clk);

        do_req(16'd0, 0);
        do_req(16'd0, 2);
        triple_req(16'd6000);

        // Reset asserted while the draw sits in CHECK.
        score = 16'd0; spawn_req = 1'b1;
        @(negedge Clk);
        spawn_req = 1'b0;
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("midrst_type", 32'(tt_a), 32'd0);
        chk("midrst_valid", 32'(tv_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_drop", 32'(drop_a), 32'd0);
        chk("midrst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        clear_history();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("midrst_novalid", 32'(tv_a), 32'd0);
            chk("midrst_idle", 32'(busy_a), 32'd0);
        end
        do_req(16'd0, 0);

        clear_stats();
        for (int i = 0; i < 500; i++) do_req(16'd0, int'($urandom_range(0, 3)));
        chk("l0_no_yellow", 32'(cnt_a[3]), 32'd0);
        chk("l0_no_brown", 32'(cnt_a[4]), 32'd0);

        clear_stats();
        for (int i = 0; i < 2000; i++) do_req(16'd6000, int'($urandom_range(0, 3)));
        chk("l3_brown_pairs", 32'(viol_b2), 32'd0);
        chk("l3_nongreen7", 32'(viol_nz7), 32'd0);
        chk("l3_brown_seen", 32'(cnt_a[4] > 0), 32'd1);

        clear_stats();
        for (int i = 0; i < 1000; i++) do_req(16'd499, int'($urandom_range(0, 3)));
        chk("s499_no_brown", 32'(cnt_a[4]), 32'd0);
        chk("s499_no_yellow", 32'(cnt_a[3]), 32'd0);

        clear_stats();
        for (int i = 0; i < 1000; i++) do_req(16'd500, int'($urandom_range(0, 3)));
        chk("s500_brown_seen", 32'(cnt_a[4] > 0), 32'd1);

        for (int i = 0; i < 300; i++) do_req(16'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));
        for (int i = 0; i < 200; i++) do_req(16'd65535, int'($urandom_range(0, 2)));
        chk("gap1_alternation", 32'(viol_g1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
